dino_game_sequencer: RTL and testbench

//  Game-flow controller that sequences the dinosaur block_controller datapath.

---
 rtl/dino_pkg.sv | 21 ++
 rtl/bcd_counter4.sv | 55 +++++
 rtl/dino_game_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dino_game_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur game sequencer.
//  - State encodings driven on the 2-bit state output.
//  - Score saturation value (4-digit BCD).
//  - Spawn LFSR polynomial taps and single-step helper.
package dino_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_DEAD      = 2'd3;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// 4-digit BCD score counter.
//  clk, rst        : clock, asynchronous active-low reset
//  i_clr           : synchronous clear to 0000 (wins over i_inc)
//  i_inc           : add one; holds at 9999
//  o_value         : current BCD value
//  o_hund_carry    : this increment changes the hundreds digit (low two digits are 99)
module bcd_counter4
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_value,
  output logic        o_hund_carry
);

  logic [15:0] r_value;
  logic [15:0] w_next;
  logic        w_sat;

  assign w_sat        = (r_value == SCORE_MAX);
  assign o_value      = r_value;
  assign o_hund_carry = i_inc && !w_sat && (r_value[7:0] == 8'h99);

  // Ripple the +1 through the digits: a 9 rolls to 0 and passes the carry on.
  always_comb begin : inc_chain
    logic carry;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_next = r_value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r_value[4*i +: 4] == 4'd9) begin
          w_next[4*i +: 4] = 4'd0;
        end else begin
          w_next[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else if (i_inc && !w_sat) begin
      r_value <= w_next;
    end
  end

endmodule

// File: rtl/dino_game_sequencer.sv
// Game-flow controller for the dinosaur block_controller datapath.
// Runs IDLE/COUNTDOWN/RUN/DEAD, paces move steps from frame ticks, issues
// jump requests and obstacle spawns, and keeps the BCD score / high score.
//  clk, rst     : clock, asynchronous active-low reset
//  frame_tick   : one-cycle pulse per VGA frame
//  up           : debounced jump button (level)
//  collision    : dino overlaps an obstacle (level)
//  state        : 0=IDLE 1=COUNTDOWN 2=RUN 3=DEAD
//  game_clr     : pulse, datapath clears positions
//  move_en      : pulse, datapath advances one step
//  jump_req     : pulse, datapath starts a jump
//  spawn        : pulse, datapath spawns an obstacle of spawn_type
//  spawn_type   : obstacle type, valid with spawn
//  speed_lvl    : speed level 0..7
//  score        : 4-digit BCD score
//  hiscore      : 4-digit BCD high score
module dino_game_sequencer
  import dino_pkg::*;
#(
  parameter int          STEP_FRAMES_INIT = 4,
  parameter int          STEP_FRAMES_MIN  = 1,
  parameter int          COUNTDOWN_FRAMES = 180,
  parameter int          DEAD_HOLD_FRAMES = 60,
  parameter int          GAP_MIN          = 40,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        up,
  input  logic        collision,
  output logic [1:0]  state,
  output logic        game_clr,
  output logic        move_en,
  output logic        jump_req,
  output logic        spawn,
  output logic [1:0]  spawn_type,
  output logic [2:0]  speed_lvl,
  output logic [15:0] score,
  output logic [15:0] hiscore
);

  logic        r_up_q;
  logic [7:0]  r_frame_cnt;   // step pacing in RUN, tick count in COUNTDOWN/DEAD
  logic [6:0]  r_gap;         // move steps left until the next spawn
  logic [15:0] r_lfsr;
  logic        r_hold_done;

  logic        w_up_rise;
  logic [7:0]  w_step_period;
  logic        w_step_due;
  logic        w_move;
  logic        w_start;
  logic        w_hund_carry;

  function automatic logic [7:0] step_period(input logic [2:0] lvl);
    int p;
    p = STEP_FRAMES_INIT - int'(lvl);
    if (p < STEP_FRAMES_MIN) p = STEP_FRAMES_MIN;
    return 8'(p);
  endfunction

  assign w_up_rise     = up && !r_up_q;
  assign w_step_period = step_period(speed_lvl);
  assign w_step_due    = frame_tick && ((r_frame_cnt + 8'd1) >= w_step_period);
  // Collision has priority: no step is taken on the cycle the dino dies.
  assign w_move        = (state == ST_RUN) && !collision && w_step_due;
  assign w_start       = w_up_rise &&
                         ((state == ST_IDLE) || ((state == ST_DEAD) && r_hold_done));

  bcd_counter4 u_score (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start),
    .i_inc        (w_move),
    .o_value      (score),
    .o_hund_carry (w_hund_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      game_clr    <= 1'b0;
      move_en     <= 1'b0;
      jump_req    <= 1'b0;
      spawn       <= 1'b0;
      spawn_type  <= 2'd0;
      speed_lvl   <= 3'd0;
      hiscore     <= 16'h0000;
      r_up_q      <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_gap       <= 7'd0;
      r_lfsr      <= LFSR_SEED;
      r_hold_done <= 1'b0;
    end else begin
      r_up_q   <= up;
      game_clr <= 1'b0;
      move_en  <= 1'b0;
      jump_req <= 1'b0;
      spawn    <= 1'b0;

      if (w_start) begin
        state       <= ST_COUNTDOWN;
        game_clr    <= 1'b1;
        speed_lvl   <= 3'd0;
        r_frame_cnt <= 8'd0;
        r_gap       <= 7'd0;   // zero gap makes the first step spawn
        r_hold_done <= 1'b0;
      end else begin
        case (state)
          ST_COUNTDOWN: begin
            if (frame_tick) begin
              if (r_frame_cnt == 8'(COUNTDOWN_FRAMES - 1)) begin
                state       <= ST_RUN;
                r_frame_cnt <= 8'd0;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
          end

          ST_RUN: begin
            if (collision) begin
              state       <= ST_DEAD;
              r_frame_cnt <= 8'd0;
              r_hold_done <= 1'b0;
              // BCD digits order the same way as the binary value.
              if (score > hiscore) hiscore <= score;
            end else begin
              if (w_up_rise) jump_req <= 1'b1;
              if (w_move) begin
                move_en     <= 1'b1;
                r_frame_cnt <= 8'd0;
                if (w_hund_carry && (speed_lvl != 3'd7)) speed_lvl <= speed_lvl + 3'd1;
                if (r_gap <= 7'd1) begin
                  spawn      <= 1'b1;
                  spawn_type <= r_lfsr[1:0];
                  r_gap      <= 7'(GAP_MIN) + 7'(r_lfsr[5:0]);
                  r_lfsr     <= lfsr_next(r_lfsr);
                end else begin
                  r_gap <= r_gap - 7'd1;
                end
              end else if (frame_tick) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
          end

          ST_DEAD: begin
            if (frame_tick && !r_hold_done) begin
              if (r_frame_cnt == 8'(DEAD_HOLD_FRAMES - 1)) r_hold_done <= 1'b1;
              else                                         r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end

          default: ;  // IDLE waits for up_rise, handled by w_start
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dino_game_sequencer.sv
module tb_dino_game_sequencer;

  logic        clk, rst, frame_tick, up, collision;
  logic [1:0]  state, spawn_type;
  logic        game_clr, move_en, jump_req, spawn;
  logic [2:0]  speed_lvl;
  logic [15:0] score, hiscore;

  dino_game_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .up(up), .collision(collision),
    .state(state), .game_clr(game_clr), .move_en(move_en), .jump_req(jump_req),
    .spawn(spawn), .spawn_type(spawn_type), .speed_lvl(speed_lvl),
    .score(score), .hiscore(hiscore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_CD = 1, S_RUN = 2, S_DEAD = 3;

  int checks = 0;
  int errors = 0;

  // Game model, expressed in terms of moves, frames and events.
  int          m_st, m_moves, m_hi, m_fr, m_cd, m_hold, m_next_spawn;
  logic [15:0] m_lfsr;
  bit          tb_up_q;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] ref_lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int m_score();
    return (m_moves > 9999) ? 9999 : m_moves;
  endfunction

  function automatic int m_speed();
    int s;
    s = m_score() / 100;
    return (s > 7) ? 7 : s;
  endfunction

  function automatic int m_period();
    int p;
    p = 4 - m_speed();
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_moves = 0; m_hi = 0; m_fr = 0; m_cd = 0; m_hold = 0;
    m_next_spawn = 1; m_lfsr = 16'hACE1; tb_up_q = 1'b0;
  endtask

  task automatic new_game();
    m_moves = 0; m_fr = 0; m_cd = 0; m_next_spawn = 1;
  endtask

  // One clock cycle: predict, drive, wait for the opposite edge, compare.
  task automatic cyc(input bit ft, input bit u, input bit col);
    bit rise, e_move, e_jump, e_spawn, e_clr;
    logic [1:0] e_type;
    rise = u && !tb_up_q;
    e_move = 0; e_jump = 0; e_spawn = 0; e_clr = 0; e_type = 2'd0;
    case (m_st)
      S_IDLE: if (rise) begin m_st = S_CD; e_clr = 1; new_game(); end
      S_CD: if (ft) begin
        m_cd++;
        if (m_cd == 180) m_st = S_RUN;
      end
      S_RUN: if (col) begin
        if (m_score() > m_hi) m_hi = m_score();
        m_st = S_DEAD; m_hold = 0;
      end else begin
        e_jump = rise;
        if (ft) begin
          if (m_fr + 1 >= m_period()) begin
            e_move = 1; m_fr = 0; m_moves++;
            if (m_moves == m_next_spawn) begin
              e_spawn = 1; e_type = m_lfsr[1:0];
              m_next_spawn = m_moves + 40 + int'(m_lfsr[5:0]);
              m_lfsr = ref_lfsr_step(m_lfsr);
            end
          end else begin
            m_fr++;
          end
        end
      end
      default: begin
        if (m_hold >= 60) begin
          if (rise) begin m_st = S_CD; e_clr = 1; new_game(); end
        end else if (ft) begin
          m_hold++;
        end
      end
    endcase
    frame_tick = ft; up = u; collision = col;
    @(negedge clk);
    tb_up_q = u;
    check("state", 16'(state), 16'(m_st));
    check("game_clr", 16'(game_clr), 16'(e_clr));
    check("move_en", 16'(move_en), 16'(e_move));
    check("jump_req", 16'(jump_req), 16'(e_jump));
    check("spawn", 16'(spawn), 16'(e_spawn));
    if (e_spawn) check("spawn_type", 16'(spawn_type), 16'(e_type));
    check("score", score, to_bcd(m_score()));
    check("hiscore", hiscore, to_bcd(m_hi));
    check("speed_lvl", 16'(speed_lvl), 16'(m_speed()));
    frame_tick = 1'b0; collision = 1'b0;
  endtask

  task automatic play_frame();
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++)
      cyc(1'b0, ($urandom_range(0, 3) == 0), (m_st == S_CD) ? 1'($urandom_range(0, 1)) : 1'b0);
    cyc(1'b1, ($urandom_range(0, 3) == 0), (m_st == S_CD) ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic play_until_run();
    int guard = 0;
    while (m_st != S_RUN && guard < 400) begin play_frame(); guard++; end
    check("reach_run", 16'(state), 16'(S_RUN));
  endtask

  task automatic play_moves(input int target);
    int guard = 0;
    while (m_moves < target && guard < 40000) begin play_frame(); guard++; end
  endtask

  task automatic make_due();
    int guard = 0;
    while ((m_fr + 1 < m_period()) && guard < 10) begin cyc(1'b1, 1'b0, 1'b0); guard++; end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 16'(state), 16'(S_IDLE));
    check({tag, "_pulses"}, 16'({game_clr, move_en, jump_req, spawn}), 16'h0);
    check({tag, "_spawn_type"}, 16'(spawn_type), 16'h0);
    check({tag, "_speed"}, 16'(speed_lvl), 16'h0);
    check({tag, "_score"}, score, 16'h0000);
    check({tag, "_hiscore"}, hiscore, 16'h0000);
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; up = 1'b0; collision = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // IDLE: frame ticks produce nothing; up_rise starts the countdown.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("start_clr", 16'(game_clr), 16'h1);
    cyc(1'b0, 1'b0, 1'b0);
    check("clr_one_cycle", 16'(game_clr), 16'h0);

    // COUNTDOWN with noisy up/collision, then RUN.
    play_until_run();

    // Speed 0: 8 frames give 2 steps.
    for (int i = 0; i < 8; i++) play_frame();
    check("score_8_frames", score, 16'h0002);

    play_moves(99);
    check("score_99", score, 16'h0099);
    play_moves(100);
    check("score_100", score, 16'h0100);
    check("speed_after_100", 16'(speed_lvl), 16'h1);

    // Collision, due step and up_rise together.
    play_moves(123);
    make_due();
    cyc(1'b1, 1'b1, 1'b1);
    check("crash_state", 16'(state), 16'(S_DEAD));
    check("crash_no_move", 16'(move_en), 16'h0);
    check("crash_no_jump", 16'(jump_req), 16'h0);
    check("crash_hiscore", hiscore, 16'h0123);

    // DEAD hold: early up_rise ignored, late one restarts.
    for (int i = 0; i < 30; i++) begin cyc(1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); end
    cyc(1'b0, 1'b1, 1'b0);
    check("early_up_state", 16'(state), 16'(S_DEAD));
    check("early_up_clr", 16'(game_clr), 16'h0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin cyc(1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("restart_state", 16'(state), 16'(S_CD));
    check("restart_clr", 16'(game_clr), 16'h1);
    check("restart_score", score, 16'h0000);
    check("restart_hiscore", hiscore, 16'h0123);

    // Long game: saturate at 9999 and keep stepping.
    cyc(1'b0, 1'b0, 1'b0);
    play_until_run();
    play_moves(10002);
    check("score_sat", score, 16'h9999);
    check("speed_max", 16'(speed_lvl), 16'h7);
    cyc(1'b0, 1'b0, 1'b1);
    check("hiscore_max", hiscore, 16'h9999);

    // Third game, reset mid-RUN.
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    play_until_run();
    play_moves(123);
    check("pre_reset_score", score, 16'h0123);
    up = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
